// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
// Holds the FSM state encoding, ALU opcode values and the opcode legality check.
package alu_issue_pkg;

   localparam int NREG = 32;
   localparam int DW   = 32;
   localparam int AW   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD       = 3'd0;
   localparam logic [2:0] OP_SUB       = 3'd1;
   localparam logic [2:0] OP_AND       = 3'd2;
   localparam logic [2:0] OP_OR        = 3'd3;
   localparam logic [2:0] OP_SRL       = 3'd4;
   localparam logic [2:0] OP_SRA       = 3'd5;
   localparam logic [2:0] OP_MAX_LEGAL = 3'd5;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_MAX_LEGAL);
   endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 32x32 register file for the issue stage.
// Register 0 ignores writes and reads as zero. Reads are combinational: two operand ports and one debug port.
module issue_regfile
   import alu_issue_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] ra_data,
   output logic [DW-1:0] rb_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] mem_r [NREG];

   // Register storage; writes to address 0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r <= '{default: '0};
      end else if (we && (waddr != 5'd0)) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign ra_data  = (ra_addr  == 5'd0) ? '0 : mem_r[ra_addr];
   assign rb_data  = (rb_addr  == 5'd0) ? '0 : mem_r[rb_addr];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue and writeback stage for the external 3-bit-opcode combinational ALU.
// Accepts a command, reads its operands, drives the ALU, and writes the result back to the register file.
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [4:0]  cmd_rs,
   input  logic [4:0]  cmd_rt,
   input  logic [4:0]  cmd_rd,
   input  logic        cmd_use_imm,
   input  logic [31:0] cmd_imm,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_c,
   output logic        done,
   output logic [31:0] result,
   output logic        err,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   state_t      state_r, next_state_s;
   logic [2:0]  op_r;
   logic [4:0]  rs_r, rt_r, rd_r;
   logic        use_imm_r;
   logic [31:0] imm_r;
   logic [31:0] rs_data_s, rt_data_s;
   logic        accept_s, exec_s, retire_s, wb_write_s;

   issue_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wb_write_s),
      .waddr    (rd_r),
      .wdata    (alu_c),
      .ra_addr  (rs_r),
      .rb_addr  (rt_r),
      .ra_data  (rs_data_s),
      .rb_data  (rt_data_s),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   always_comb begin
      next_state_s = IDLE;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               next_state_s = EXEC;
            end else begin
               next_state_s = IDLE;
            end
         end
         EXEC:    next_state_s = WB;
         WB:      next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      exec_s    = 1'b0;
      retire_s  = 1'b0;
      case (state_r)
         IDLE:    cmd_ready = 1'b1;
         EXEC:    exec_s    = 1'b1;
         WB:      retire_s  = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign accept_s   = cmd_ready & cmd_valid;
   assign wb_write_s = retire_s & op_legal(op_r);

   // Command fields are latched at acceptance; operands are read later, in EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r      <= 3'd0;
         rs_r      <= 5'd0;
         rt_r      <= 5'd0;
         rd_r      <= 5'd0;
         use_imm_r <= 1'b0;
         imm_r     <= 32'd0;
      end else if (accept_s) begin
         op_r      <= cmd_op;
         rs_r      <= cmd_rs;
         rt_r      <= cmd_rt;
         rd_r      <= cmd_rd;
         use_imm_r <= cmd_use_imm;
         imm_r     <= cmd_imm;
      end
   end

   // The ALU inputs are loaded from the EXEC-cycle register read, so alu_c is valid while in WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= 32'd0;
         alu_b  <= 32'd0;
         alu_op <= 3'd0;
      end else if (exec_s) begin
         alu_a  <= rs_data_s;
         alu_b  <= use_imm_r ? imm_r : rt_data_s;
         alu_op <= op_r;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done   <= 1'b0;
         err    <= 1'b0;
         result <= 32'd0;
      end else begin
         done <= retire_s;
         err  <= retire_s & ~op_legal(op_r);
         if (wb_write_s) begin
            result <= alu_c;
         end
      end
   end

endmodule
